// File: rtl/cfa_gradient_engine_if.sv
// ---------------------------------------------------------------------------
// cfa_gradient_engine_if
// Column-in / gradient-out handshake bundle for cfa_gradient_engine.
//   master : column feeder + downstream consumer side (drives col_*, out_ready)
//   slave  : the gradient engine itself
// Signals:
//   col_valid/col_ready/col_sof/col_data : column stream (row -2 at LSBs)
//   out_valid/out_ready                  : gradient result handshake
//   grad_hs/grad_vs/grad_hf/grad_vf      : scaled, saturated gradients
//   weight, w_grad_hf, w_grad_vf         : only when WEIGHTED_FLAT_EN is defined
// Optional feature macro: WEIGHTED_FLAT_EN
// ---------------------------------------------------------------------------
interface cfa_gradient_engine_if #(
  parameter int PIX_W = 12,
  parameter int OUT_W = 8
);
  logic               col_valid;
  logic               col_ready;
  logic               col_sof;
  logic [5*PIX_W-1:0] col_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   grad_hs;
  logic [OUT_W-1:0]   grad_vs;
  logic [OUT_W-1:0]   grad_hf;
  logic [OUT_W-1:0]   grad_vf;
`ifdef WEIGHTED_FLAT_EN
  logic [OUT_W-1:0]   weight;
  logic [OUT_W-1:0]   w_grad_hf;
  logic [OUT_W-1:0]   w_grad_vf;

  modport master (
    output col_valid, col_sof, col_data, out_ready, weight,
    input  col_ready, out_valid, grad_hs, grad_vs, grad_hf, grad_vf,
           w_grad_hf, w_grad_vf
  );
  modport slave (
    input  col_valid, col_sof, col_data, out_ready, weight,
    output col_ready, out_valid, grad_hs, grad_vs, grad_hf, grad_vf,
           w_grad_hf, w_grad_vf
  );
`else
  modport master (
    output col_valid, col_sof, col_data, out_ready,
    input  col_ready, out_valid, grad_hs, grad_vs, grad_hf, grad_vf
  );
  modport slave (
    input  col_valid, col_sof, col_data, out_ready,
    output col_ready, out_valid, grad_hs, grad_vs, grad_hf, grad_vf
  );
`endif
endinterface

// File: rtl/cfa_gradient_engine.sv
// ---------------------------------------------------------------------------
// cfa_gradient_engine
// Streaming 5x5 gradient engine for the CFA demosaic path. Takes one 5-pixel
// column per handshake, keeps a sliding 5x5 window and, for every complete
// window, produces smooth H/V and flat H/V gradients, scaled by >> SCALE_SH
// and saturated to OUT_W bits.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : cfa_gradient_engine_if.slave (column in, gradients out)
// Pipeline: window register, S1 (row/column sums), S2 (raw gradients),
//   S3 (scale + saturate), plus S4 (flat-gradient weighting) when the
//   WEIGHTED_FLAT_EN macro is defined. One global enable stalls every stage.
// ---------------------------------------------------------------------------
module cfa_gradient_engine #(
  parameter int PIX_W    = 12,
  parameter int OUT_W    = 8,
  parameter int SCALE_SH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cfa_gradient_engine_if.slave  bus
);
  localparam int SUM_W = PIX_W + 3;
  localparam int P_W   = PIX_W + 5;
  localparam int RAW_W = PIX_W + 7;
  // Signed room for 5*c - P without wrap.
  localparam int DIF_W = PIX_W + 9;

  function automatic logic signed [DIF_W-1:0] times5(input logic [SUM_W-1:0] x);
    logic signed [DIF_W-1:0] xs;
    xs = DIF_W'(x);
    return xs + (xs <<< 2);
  endfunction

  function automatic logic [RAW_W-1:0] abs_diff(input logic signed [DIF_W-1:0] a,
                                                input logic signed [DIF_W-1:0] b);
    logic signed [DIF_W-1:0] d;
    d = a - b;
    return (d < 0) ? RAW_W'(-d) : RAW_W'(d);
  endfunction

  function automatic logic [OUT_W-1:0] scale_sat(input logic [RAW_W-1:0] raw);
    logic [RAW_W-1:0] sh;
    sh = raw >> SCALE_SH;
    if (sh > RAW_W'({OUT_W{1'b1}})) return '1;
    return OUT_W'(sh);
  endfunction

`ifdef WEIGHTED_FLAT_EN
  function automatic logic [OUT_W-1:0] weigh(input logic [OUT_W-1:0] g,
                                             input logic [OUT_W-1:0] w);
    logic [2*OUT_W-1:0] prod;
    prod = {{OUT_W{1'b0}}, g} * {{OUT_W{1'b0}}, w};
    return prod[2*OUT_W-1:OUT_W];
  endfunction
`endif

  logic             en, accept, out_vld;
  logic [2:0]       fill, fill_next;
  logic [PIX_W-1:0] win_p0 [5][5];   // [column][row], column 4 is the newest
  logic             vld_p0;
  logic [SUM_W-1:0] row_sum [5];
  logic [SUM_W-1:0] col_sum [5];
  logic [P_W-1:0]   p_sum;
  logic [SUM_W-1:0] row_p1 [5];
  logic [SUM_W-1:0] col_p1 [5];
  logic [P_W-1:0]   p_p1;
  logic             vld_p1;
  logic [RAW_W-1:0] hs_raw, vs_raw, hf_raw, vf_raw;
  logic [RAW_W-1:0] hs_p2, vs_p2, hf_p2, vf_p2;
  logic             vld_p2;
  logic [OUT_W-1:0] hs_p3, vs_p3, hf_p3, vf_p3;
  logic             vld_p3;
`ifdef WEIGHTED_FLAT_EN
  logic [OUT_W-1:0] hs_p4, vs_p4, hf_p4, vf_p4, whf_p4, wvf_p4;
  logic             vld_p4;
`endif

  assign en            = !out_vld || bus.out_ready;
  assign accept        = bus.col_valid && en;
  assign bus.col_ready = en;

  // sof restarts the fill count at 1, so older columns never complete a window.
  always_comb begin
    fill_next = fill;
    if (bus.col_sof)         fill_next = 3'd1;
    else if (fill != 3'd5)   fill_next = fill + 3'd1;
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      row_sum[k] = '0;
      col_sum[k] = '0;
    end
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 5; i++) begin
        col_sum[j] = col_sum[j] + SUM_W'(win_p0[j][i]);
        row_sum[i] = row_sum[i] + SUM_W'(win_p0[j][i]);
      end
    end
    p_sum = '0;
    for (int j = 0; j < 5; j++) p_sum = p_sum + P_W'(col_sum[j]);
  end

  always_comb begin
    hs_raw = '0;
    vs_raw = '0;
    hf_raw = '0;
    vf_raw = '0;
    for (int k = 0; k < 4; k++) begin
      hs_raw = hs_raw + abs_diff(DIF_W'(col_p1[k]), DIF_W'(col_p1[k+1]));
      vs_raw = vs_raw + abs_diff(DIF_W'(row_p1[k]), DIF_W'(row_p1[k+1]));
    end
    for (int k = 0; k < 5; k++) begin
      hf_raw = hf_raw + abs_diff(times5(col_p1[k]), DIF_W'(p_p1));
      vf_raw = vf_raw + abs_diff(times5(row_p1[k]), DIF_W'(p_p1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill   <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      for (int j = 0; j < 5; j++) begin
        for (int i = 0; i < 5; i++) win_p0[j][i] <= '0;
        row_p1[j] <= '0;
        col_p1[j] <= '0;
      end
      p_p1  <= '0;
      hs_p2 <= '0; vs_p2 <= '0; hf_p2 <= '0; vf_p2 <= '0;
      hs_p3 <= '0; vs_p3 <= '0; hf_p3 <= '0; vf_p3 <= '0;
`ifdef WEIGHTED_FLAT_EN
      vld_p4 <= 1'b0;
      hs_p4  <= '0; vs_p4 <= '0; hf_p4 <= '0; vf_p4 <= '0;
      whf_p4 <= '0; wvf_p4 <= '0;
`endif
    end else if (en) begin
      // p0: window shift; a cycle without accept launches a bubble
      if (accept) begin
        for (int j = 0; j < 4; j++)
          for (int i = 0; i < 5; i++) win_p0[j][i] <= win_p0[j+1][i];
        for (int i = 0; i < 5; i++) win_p0[4][i] <= bus.col_data[i*PIX_W +: PIX_W];
        fill <= fill_next;
      end
      vld_p0 <= accept && (fill_next == 3'd5);
      // p1: row/column sums
      for (int k = 0; k < 5; k++) begin
        row_p1[k] <= row_sum[k];
        col_p1[k] <= col_sum[k];
      end
      p_p1   <= p_sum;
      vld_p1 <= vld_p0;
      // p2: raw gradients
      hs_p2  <= hs_raw;
      vs_p2  <= vs_raw;
      hf_p2  <= hf_raw;
      vf_p2  <= vf_raw;
      vld_p2 <= vld_p1;
      // p3: scale and saturate
      hs_p3  <= scale_sat(hs_p2);
      vs_p3  <= scale_sat(vs_p2);
      hf_p3  <= scale_sat(hf_p2);
      vf_p3  <= scale_sat(vf_p2);
      vld_p3 <= vld_p2;
`ifdef WEIGHTED_FLAT_EN
      // p4: flat-gradient weighting, weight sampled here
      hs_p4  <= hs_p3;
      vs_p4  <= vs_p3;
      hf_p4  <= hf_p3;
      vf_p4  <= vf_p3;
      whf_p4 <= weigh(hf_p3, bus.weight);
      wvf_p4 <= weigh(vf_p3, bus.weight);
      vld_p4 <= vld_p3;
`endif
    end
  end

`ifdef WEIGHTED_FLAT_EN
  assign out_vld       = vld_p4;
  assign bus.grad_hs   = hs_p4;
  assign bus.grad_vs   = vs_p4;
  assign bus.grad_hf   = hf_p4;
  assign bus.grad_vf   = vf_p4;
  assign bus.w_grad_hf = whf_p4;
  assign bus.w_grad_vf = wvf_p4;
`else
  assign out_vld       = vld_p3;
  assign bus.grad_hs   = hs_p3;
  assign bus.grad_vs   = vs_p3;
  assign bus.grad_hf   = hf_p3;
  assign bus.grad_vf   = vf_p3;
`endif
  assign bus.out_valid = out_vld;

endmodule

// File: tb/tb_cfa_gradient_engine.sv
// ---------------------------------------------------------------------------
// tb_cfa_gradient_engine
// Self-checking bench for cfa_gradient_engine. A behavioural window model
// turns every accepted column into an expected result (queued); one negedge
// process compares outputs, latency, stall behaviour and reset state.
// Honours WEIGHTED_FLAT_EN (weight fixed at 128).
// ---------------------------------------------------------------------------
module tb_cfa_gradient_engine;
  localparam int PIX_W = 12;
  localparam int OUT_W = 8;
`ifdef WEIGHTED_FLAT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int WEIGHT = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cfa_gradient_engine_if #(.PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();
  cfa_gradient_engine #(.PIX_W(PIX_W), .OUT_W(OUT_W), .SCALE_SH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int hs; int vs; int hf; int vf; int whf; int wvf;
    int acc_cyc; int acc_stalls;
  } exp_t;

  exp_t q[$];
  int   mw [5][5];
  int   mfill = 0;
  int   n_cmp = 0, n_fail = 0, cyc = 0, stalls = 0;
  bit   front_seen = 0, rst_prev = 1, final_chk = 0, final_done = 0, stim_done = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int sat8(input int raw);
    return ((raw / 16) > 255) ? 255 : raw / 16;
  endfunction

  function automatic int weigh_m(input int g, input int w);
    return (g * w) / 256;
  endfunction

  // Gradients straight from the definitions: column sums c, row sums r, total P.
  function automatic void model_grad(input int w [5][5], output int hs, output int vs,
                                     output int hf, output int vf);
    int c [5];
    int r [5];
    int p;
    p = 0;
    for (int k = 0; k < 5; k++) begin c[k] = 0; r[k] = 0; end
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < 5; i++) begin
        c[j] += w[j][i];
        r[i] += w[j][i];
      end
    for (int k = 0; k < 5; k++) p += c[k];
    hs = 0; vs = 0; hf = 0; vf = 0;
    for (int k = 0; k < 4; k++) begin
      hs += iabs(c[k] - c[k+1]);
      vs += iabs(r[k] - r[k+1]);
    end
    for (int k = 0; k < 5; k++) begin
      hf += iabs(5 * c[k] - p);
      vf += iabs(5 * r[k] - p);
    end
    hs = sat8(hs); vs = sat8(vs); hf = sat8(hf); vf = sat8(vf);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_accept(input logic [5*PIX_W-1:0] d, input logic sof);
    exp_t e;
    int hs, vs, hf, vf;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 5; i++) mw[j][i] = mw[j+1][i];
    for (int i = 0; i < 5; i++) mw[4][i] = int'(d[i*PIX_W +: PIX_W]);
    if (sof) mfill = 1;
    else if (mfill < 5) mfill++;
    if (mfill == 5) begin
      model_grad(mw, hs, vs, hf, vf);
      e.hs = hs; e.vs = vs; e.hf = hf; e.vf = vf;
      e.whf = weigh_m(hf, WEIGHT);
      e.wvf = weigh_m(vf, WEIGHT);
      e.acc_cyc = cyc;
      e.acc_stalls = stalls;
      q.push_back(e);
    end
  endtask

  // Single compare process: every negedge.
  always @(negedge clk) begin : compare
    int pw [5][5];
    int hs, vs, hf, vf;
    exp_t e;
    cyc++;
    if (cyc == 1) begin
      for (int j = 0; j < 5; j++) for (int i = 0; i < 5; i++) pw[j][i] = 100 * j;
      model_grad(pw, hs, vs, hf, vf);
      chk("pin_ramp_hs", hs, 125);
      chk("pin_ramp_vs", vs, 0);
      chk("pin_ramp_hf", hf, 255);
      chk("pin_ramp_vf", vf, 0);
      for (int j = 0; j < 5; j++) for (int i = 0; i < 5; i++) pw[j][i] = (j == 4) ? 16 : 0;
      model_grad(pw, hs, vs, hf, vf);
      chk("pin_edge_hs", hs, 5);
      chk("pin_edge_hf", hf, 40);
      chk("pin_edge_vf", vf, 0);
      chk("pin_weight", weigh_m(255, WEIGHT), 127);
    end
    if (!rst) begin
      q.delete();
      mfill = 0;
      front_seen = 0;
      for (int j = 0; j < 5; j++) for (int i = 0; i < 5; i++) mw[j][i] = 0;
    end else begin
      if (!rst_prev) begin
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_grad_hs", int'(bus.grad_hs), 0);
        chk("reset_grad_vs", int'(bus.grad_vs), 0);
        chk("reset_grad_hf", int'(bus.grad_hf), 0);
        chk("reset_grad_vf", int'(bus.grad_vf), 0);
        chk("reset_col_ready", int'(bus.col_ready), 1);
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("out_valid_unexpected", int'(bus.out_valid), 0);
        end else begin
          e = q[0];
          if (!front_seen) begin
            chk("latency_cycle", cyc, e.acc_cyc + LAT + 1 + (stalls - e.acc_stalls));
            front_seen = 1;
          end
          chk("grad_hs", int'(bus.grad_hs), e.hs);
          chk("grad_vs", int'(bus.grad_vs), e.vs);
          chk("grad_hf", int'(bus.grad_hf), e.hf);
          chk("grad_vf", int'(bus.grad_vf), e.vf);
`ifdef WEIGHTED_FLAT_EN
          chk("w_grad_hf", int'(bus.w_grad_hf), e.whf);
          chk("w_grad_vf", int'(bus.w_grad_vf), e.wvf);
`endif
          if (bus.out_ready) begin
            void'(q.pop_front());
            front_seen = 0;
          end else begin
            chk("col_ready_stalled", int'(bus.col_ready), 0);
          end
        end
      end
      if (bus.col_valid && bus.col_ready) model_accept(bus.col_data, bus.col_sof);
      if (bus.out_valid && !bus.out_ready) stalls++;
    end
    if (final_chk && !final_done) begin
      chk("windows_outstanding", q.size(), 0);
      final_done = 1;
    end
    rst_prev = rst;
  end

  function automatic logic [5*PIX_W-1:0] ucol(input int v);
    return {5{PIX_W'(v)}};
  endfunction

  function automatic logic [5*PIX_W-1:0] mkcol(input int s);
    logic [5*PIX_W-1:0] d;
    for (int i = 0; i < 5; i++) d[i*PIX_W +: PIX_W] = PIX_W'(s * 53 + i * i * 97 + s * s * 7);
    return d;
  endfunction

  function automatic logic [5*PIX_W-1:0] rnd_col();
    logic [5*PIX_W-1:0] d;
    d[31:0]  = $urandom;
    d[59:32] = 28'($urandom);
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5*PIX_W-1:0] d, input logic sof);
    bit ok;
    bus.col_valid = 1'b1;
    bus.col_data  = d;
    bus.col_sof   = sof;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      ok = bus.col_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        bus.col_valid = 1'b0;
        bus.col_sof   = 1'b0;
        return;
      end
    end
    $display("FAIL put_timeout: col_ready low for 200 cycles, required high");
    $fatal(1, "column handshake never completed");
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    idle(3);
  endtask

  initial begin
    bus.col_valid = 1'b0;
    bus.col_sof   = 1'b0;
    bus.col_data  = '0;
    bus.out_ready = 1'b1;
`ifdef WEIGHTED_FLAT_EN
    bus.weight    = OUT_W'(WEIGHT);
`endif
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // flat patch
    for (int k = 0; k < 5; k++) put(ucol(12), k == 0);
    drain();
    // horizontal ramp
    for (int k = 0; k < 5; k++) put(ucol(100 * k), k == 0);
    drain();
    // sof mid-stream on the 8th column
    for (int k = 0; k < 12; k++) put(mkcol(k + 3), (k == 0) || (k == 7));
    drain();
    // backpressure: 4 stalled cycles while a result is held
    fork
      for (int k = 0; k < 10; k++) put(mkcol(k + 20), k == 0);
      begin
        for (int g = 0; g < 60 && !bus.out_valid; g++) begin
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b0;
        idle(4);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    // reset with two windows in flight, then 5 fresh columns without sof
    for (int k = 0; k < 6; k++) put(mkcol(k + 40), k == 0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(2);
    for (int k = 0; k < 5; k++) put(mkcol(k + 50), 1'b0);
    drain();
    // randomized columns, sof and backpressure
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(3) != 0) put(rnd_col(), $urandom_range(15) == 0);
          else idle(1);
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    final_chk = 1;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
